// File: rtl/fft_input_pairer.sv
// fft_input_pairer: buffers one FFT frame, then replays it as (k, k+N/2) pairs under a contiguous start window.
// Define FFT_IN_CPLX_EN to store and replay imaginary parts; otherwise the imag outputs are tied to 0.
module fft_input_pairer #(
    parameter int FFT_SIZE = 1024,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = $clog2(FFT_SIZE)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] s_re_i,
    input  logic [DATA_W-1:0] s_im_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic              dst_idle_i,
    output logic              start_o,
    output logic [DATA_W-1:0] x0_re_o,
    output logic [DATA_W-1:0] x0_im_o,
    output logic [DATA_W-1:0] x1_re_o,
    output logic [DATA_W-1:0] x1_im_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int HALF = FFT_SIZE / 2;
    localparam int AW   = CNT_W - 1;
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(FFT_SIZE - 1);
    localparam logic [AW-1:0]    R_LAST = AW'(HALF - 1);

    typedef enum logic [1:0] {FILL, WAIT, STREAM, TAIL} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [AW-1:0]     rcnt_q, rcnt_d;
    logic              pair_vld_q, done_q;
    logic              wr_en;
    logic [DATA_W-1:0] a_re_mem [HALF];
    logic [DATA_W-1:0] b_re_mem [HALF];
    logic [DATA_W-1:0] a_re_q, b_re_q;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        wr_en   = 1'b0;
        case (state_q)
            FILL: begin
                wr_en = s_valid_i;
                if (s_valid_i) wcnt_d = wcnt_q + CNT_W'(1);
                if (s_valid_i && wcnt_q == W_LAST) state_d = WAIT;
            end
            WAIT:   state_d = dst_idle_i ? STREAM : WAIT;
            STREAM: begin
                rcnt_d = rcnt_q + AW'(1);
                if (rcnt_q == R_LAST) state_d = TAIL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= FILL;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            pair_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            pair_vld_q <= state_q == STREAM;
            done_q     <= state_q == TAIL;
        end
    end

    // MSB of the write counter selects the half; RAMs are unreset storage.
    always_ff @(posedge clk) begin
        if (wr_en && !wcnt_q[AW]) a_re_mem[wcnt_q[AW-1:0]] <= s_re_i;
        if (wr_en && wcnt_q[AW]) b_re_mem[wcnt_q[AW-1:0]] <= s_re_i;
        a_re_q <= a_re_mem[rcnt_q];
        b_re_q <= b_re_mem[rcnt_q];
    end

`ifdef FFT_IN_CPLX_EN
    logic [DATA_W-1:0] a_im_mem [HALF];
    logic [DATA_W-1:0] b_im_mem [HALF];
    logic [DATA_W-1:0] a_im_q, b_im_q;

    always_ff @(posedge clk) begin
        if (wr_en && !wcnt_q[AW]) a_im_mem[wcnt_q[AW-1:0]] <= s_im_i;
        if (wr_en && wcnt_q[AW]) b_im_mem[wcnt_q[AW-1:0]] <= s_im_i;
        a_im_q <= a_im_mem[rcnt_q];
        b_im_q <= b_im_mem[rcnt_q];
    end

    assign x0_im_o = pair_vld_q ? a_im_q : '0;
    assign x1_im_o = pair_vld_q ? b_im_q : '0;
`else
    logic unused_im;
    assign unused_im = ^s_im_i;
    assign x0_im_o   = '0;
    assign x1_im_o   = '0;
`endif

    assign s_ready_o    = rstn && state_q == FILL;
    assign start_o      = state_q == STREAM;
    assign busy_o       = state_q != FILL;
    assign frame_done_o = done_q;
    assign x0_re_o      = pair_vld_q ? a_re_q : '0;
    assign x1_re_o      = pair_vld_q ? b_re_q : '0;
endmodule

// File: tb/tb_fft_input_pairer.sv
// tb_fft_input_pairer: table-driven frames plus hand-written wait/back-to-back/reset sequences,
// with a pair scoreboard filled while samples are driven and drained when pairs appear.
module tb_fft_input_pairer;
    localparam int N  = 1024;
    localparam int H  = N / 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_re_i = '0, s_im_i = '0;
    logic          s_valid_i = 1'b0, dst_idle_i = 1'b1;
    logic          s_ready_o, start_o, busy_o, frame_done_o;
    logic [DW-1:0] x0_re_o, x0_im_o, x1_re_o, x1_im_o;

    fft_input_pairer dut (
        .clk(clk), .rstn(rstn), .s_re_i(s_re_i), .s_im_i(s_im_i), .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o), .dst_idle_i(dst_idle_i), .start_o(start_o),
        .x0_re_o(x0_re_o), .x0_im_o(x0_im_o), .x1_re_o(x1_re_o), .x1_im_o(x1_im_o),
        .busy_o(busy_o), .frame_done_o(frame_done_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4*DW-1:0] exp_q[$];
    logic p1 = 1'b0, p2 = 1'b0;
    int run_len = 0, n_done = 0, t_start = 0, t_done = 0;

    function automatic void chk(string name, logic [4*DW-1:0] act, logic [4*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or event missing", name);
    endfunction

    function automatic logic [DW-1:0] im_exp(logic [DW-1:0] v);
`ifdef FFT_IN_CPLX_EN
        return v;
`else
        return v & '0;
`endif
    endfunction

    // Monitor: a pair is due one cycle after each start cycle, zeros otherwise.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            p1 = 1'b0;
            p2 = 1'b0;
            run_len = 0;
        end else begin
            if (p1) begin
                if (exp_q.size() == 0) fail("pair_underflow");
                else chk("pair", {x0_re_o, x1_re_o, x0_im_o, x1_im_o}, exp_q.pop_front());
            end else chk("x_idle_zero", {x0_re_o, x1_re_o, x0_im_o, x1_im_o}, '0);
            if (start_o) begin
                if (run_len == 0) t_start = cyc;
                run_len++;
            end else if (run_len != 0) begin
                chk("start_run_len", run_len, H);
                run_len = 0;
            end
            if (frame_done_o || (p2 && !p1)) chk("frame_done", frame_done_o, p2 && !p1);
            if (frame_done_o) begin
                n_done++;
                t_done = cyc;
            end
            p2 = p1;
            p1 = start_o;
        end
    end

    task automatic drive_frame(input int base, input bit toggle, output int t_first, output int t_last);
        logic [DW-1:0] re_h[H];
        logic [DW-1:0] im_h[H];
        int n = 0;
        t_first = -1;
        t_last = -1;
        for (int k = 1; k <= 4 * N && n < N; k++) begin
            @(negedge clk);
            s_valid_i = toggle ? k[0] : 1'b1;
            s_re_i = DW'(base + n);
            s_im_i = DW'(-n);
            if (s_valid_i && s_ready_o) begin
                if (t_first < 0) t_first = cyc;
                t_last = cyc;
                if (n < H) begin
                    re_h[n] = s_re_i;
                    im_h[n] = s_im_i;
                end else exp_q.push_back({re_h[n-H], s_re_i, im_exp(im_h[n-H]), im_exp(s_im_i)});
                n++;
            end
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        if (n < N) fail("fill_timeout");
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) @(negedge clk);
        if (n_done == d0) fail("done_timeout");
        @(negedge clk);
    endtask

    typedef struct {
        int base;
        bit toggle;
        int idle_low;
        int lat;
    } vec_t;

    vec_t tbl[3];
    int   tf, tl, tf2, tl2, ref_t, d0;

    initial begin
        tbl[0] = '{base: 0,   toggle: 1'b0, idle_low: 0,   lat: 2};
        tbl[1] = '{base: 0,   toggle: 1'b1, idle_low: 0,   lat: 2};
        tbl[2] = '{base: 300, toggle: 1'b0, idle_low: 100, lat: 1};

        #2;
        chk("rst_ready", s_ready_o, 0);
        chk("rst_outs", {start_o, busy_o, frame_done_o}, 0);
        chk("rst_x", {x0_re_o, x1_re_o, x0_im_o, x1_im_o}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready_after_release", {s_ready_o, busy_o}, 2'b10);

        for (int i = 0; i < 3; i++) begin
            dst_idle_i = tbl[i].idle_low == 0;
            d0 = n_done;
            drive_frame(tbl[i].base, tbl[i].toggle, tf, tl);
            ref_t = tl;
            for (int j = 0; j < tbl[i].idle_low; j++) begin
                @(negedge clk);
                chk("wait_hold", {start_o, busy_o, s_ready_o}, 3'b010);
            end
            if (tbl[i].idle_low != 0) begin
                dst_idle_i = 1'b1;
                ref_t = cyc;
            end
            wait_done(N);
            chk("start_latency", t_start - ref_t, tbl[i].lat);
            chk("done_count", n_done - d0, 1);
            chk("queue_empty", exp_q.size(), 0);
        end

        // Back-to-back: the second frame is offered immediately, idle drops mid-stream.
        d0 = n_done;
        drive_frame(0, 1'b0, tf, tl);
        repeat (10) @(negedge clk);
        dst_idle_i = 1'b0;
        drive_frame(1000, 1'b0, tf2, tl2);
        chk("b2b_accept_at_done", tf2, t_done);
        dst_idle_i = 1'b1;
        wait_done(N);
        chk("b2b_done_count", n_done - d0, 2);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Reset while read index 200 is being issued.
        drive_frame(0, 1'b0, tf, tl);
        for (int i = 0; i < 100 && !start_o; i++) @(negedge clk);
        if (!start_o) fail("stream_timeout");
        repeat (200) @(posedge clk);
        #1;
        chk("pre_reset_start", start_o, 1);
        rstn = 1'b0;
        #1;
        chk("midrst_outs", {start_o, busy_o, s_ready_o, frame_done_o}, 0);
        chk("midrst_x", {x0_re_o, x1_re_o, x0_im_o, x1_im_o}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midrst_release", {s_ready_o, busy_o}, 2'b10);
        d0 = n_done;
        drive_frame(7, 1'b0, tf, tl);
        wait_done(N);
        chk("post_rst_done_count", n_done - d0, 1);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
